// File: rtl/instruction_fetch_unit.sv
// ============================================================================
// Module   : instruction_fetch_unit
// Brief    : Fetch stage that reads instructions at PC_in over a req/ack
//            memory handshake. It holds each fetched word in IR for decode and
//            pulses PCWrite so the PC stage advances. It also handles flushes
//            when control redirects the PC.
//            Optional macro FETCH_TIMEOUT_EN adds a REQ timeout that raises a
//            sticky Fetch_Error and parks the unit in HALT until reset.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module instruction_fetch_unit #(
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        Enable,
    input  logic [15:0] PC_in,
    input  logic        Mem_Ack,
    input  logic [15:0] Mem_Data,
    input  logic        IR_Take,
    input  logic        Flush,
    output logic        Mem_Req,
    output logic [15:0] Mem_Addr,
    output logic [15:0] IR,
    output logic        IR_Valid,
    output logic [15:0] Fetch_PC,
    output logic        PCWrite,
    output logic        Fetch_Error
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_FULL = 2'd2
`ifdef FETCH_TIMEOUT_EN
        , S_HALT = 2'd3
`endif
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] ir_q, ir_d;
    logic [15:0] fetch_pc_q, fetch_pc_d;
    logic        ir_valid_q, ir_valid_d;
    logic        pcwrite_q, pcwrite_d;
    logic        drop_q, drop_d;
`ifdef FETCH_TIMEOUT_EN
    localparam logic [3:0] c_TIMEOUT_LAST = 4'(TIMEOUT_CYCLES - 1);
    logic [3:0]  cnt_q, cnt_d;
    logic        err_q, err_d;
`endif

    always_comb begin
        state_d    = state_q;
        ir_d       = ir_q;
        fetch_pc_d = fetch_pc_q;
        ir_valid_d = ir_valid_q;
        pcwrite_d  = 1'b0;
        drop_d     = drop_q;
`ifdef FETCH_TIMEOUT_EN
        cnt_d      = cnt_q;
        err_d      = err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (Flush || Enable) begin
                    state_d    = S_REQ;
                    ir_valid_d = 1'b0;
                    drop_d     = 1'b0;
`ifdef FETCH_TIMEOUT_EN
                    cnt_d      = 4'd0;
`endif
                end
            end
            S_REQ: begin
                if (Mem_Ack) begin
`ifdef FETCH_TIMEOUT_EN
                    cnt_d = 4'd0;
`endif
                    // A flush raised now or earlier in this request makes the
                    // returned word stale; re-request at the redirected PC.
                    if (drop_q || Flush) begin
                        drop_d = 1'b0;
                    end else begin
                        ir_d       = Mem_Data;
                        fetch_pc_d = PC_in;
                        ir_valid_d = 1'b1;
                        pcwrite_d  = 1'b1;
                        state_d    = S_FULL;
                    end
                end else begin
                    if (Flush) begin
                        drop_d = 1'b1;
                    end
`ifdef FETCH_TIMEOUT_EN
                    if (cnt_q == c_TIMEOUT_LAST) begin
                        err_d   = 1'b1;
                        state_d = S_HALT;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
`endif
                end
            end
            S_FULL: begin
                if (Flush || IR_Take) begin
                    ir_valid_d = 1'b0;
                    drop_d     = 1'b0;
                    state_d    = S_REQ;
`ifdef FETCH_TIMEOUT_EN
                    cnt_d      = 4'd0;
`endif
                end
            end
            default: begin
                state_d = state_q;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!Reset) begin
            state_q    <= S_IDLE;
            ir_q       <= 16'd0;
            fetch_pc_q <= 16'd0;
            ir_valid_q <= 1'b0;
            pcwrite_q  <= 1'b0;
            drop_q     <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
            cnt_q      <= 4'd0;
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            ir_q       <= ir_d;
            fetch_pc_q <= fetch_pc_d;
            ir_valid_q <= ir_valid_d;
            pcwrite_q  <= pcwrite_d;
            drop_q     <= drop_d;
`ifdef FETCH_TIMEOUT_EN
            cnt_q      <= cnt_d;
            err_q      <= err_d;
`endif
        end
    end

    assign Mem_Req  = (state_q == S_REQ);
    assign Mem_Addr = Mem_Req ? PC_in : 16'd0;
    assign IR       = ir_q;
    assign IR_Valid = ir_valid_q;
    assign Fetch_PC = fetch_pc_q;
    assign PCWrite  = pcwrite_q;
`ifdef FETCH_TIMEOUT_EN
    assign Fetch_Error = err_q;
`else
    assign Fetch_Error = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_instruction_fetch_unit.sv
// ============================================================================
// Module   : tb_instruction_fetch_unit
// Brief    : Vector-table bench for instruction_fetch_unit, with a simple PC
//            stage stand-in (PC+2 on PCWrite, load on redirect).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instruction_fetch_unit;

    logic        CLK = 1'b0;
    logic        Reset, Enable, Mem_Ack, IR_Take, Flush;
    logic [15:0] Mem_Data;
    logic        Mem_Req, IR_Valid, PCWrite, Fetch_Error;
    logic [15:0] Mem_Addr, IR, Fetch_PC;
    logic [15:0] pc;
    logic        pc_ld;
    logic [15:0] pc_ldv;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 CLK = ~CLK;

    // PC stage stand-in: a control load wins over the PCWrite increment.
    always @(posedge CLK) begin
        if (pc_ld)        pc <= pc_ldv;
        else if (PCWrite) pc <= pc + 16'd2;
    end

    instruction_fetch_unit #(.TIMEOUT_CYCLES(15)) dut (
        .CLK        (CLK),
        .Reset      (Reset),
        .Enable     (Enable),
        .PC_in      (pc),
        .Mem_Ack    (Mem_Ack),
        .Mem_Data   (Mem_Data),
        .IR_Take    (IR_Take),
        .Flush      (Flush),
        .Mem_Req    (Mem_Req),
        .Mem_Addr   (Mem_Addr),
        .IR         (IR),
        .IR_Valid   (IR_Valid),
        .Fetch_PC   (Fetch_PC),
        .PCWrite    (PCWrite),
        .Fetch_Error(Fetch_Error)
    );

    typedef struct {
        logic        rst_n, en, ack;
        logic [15:0] data;
        logic        take, flush, ld;
        logic [15:0] ldv;
        logic        chk;
        logic        req;
        logic [15:0] addr, ir;
        logic        val;
        logic [15:0] fpc;
        logic        pcw;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(logic rst_n, logic en, logic ack, logic [15:0] data,
                                logic take, logic flush, logic ld, logic [15:0] ldv,
                                logic chk, logic req, logic [15:0] addr, logic [15:0] ir,
                                logic val, logic [15:0] fpc, logic pcw);
        vec_t v;
        v.rst_n = rst_n; v.en = en; v.ack = ack; v.data = data;
        v.take = take; v.flush = flush; v.ld = ld; v.ldv = ldv;
        v.chk = chk; v.req = req; v.addr = addr; v.ir = ir;
        v.val = val; v.fpc = fpc; v.pcw = pcw;
        return v;
    endfunction

    task automatic check(string name, logic [15:0] act, logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        Reset = 1'b1; Enable = 1'b0; Mem_Ack = 1'b0; Mem_Data = 16'd0;
        IR_Take = 1'b0; Flush = 1'b0; pc_ld = 1'b0; pc_ldv = 16'd0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //             rst en ack data     tk fl ld ldv       chk req addr     ir       val fpc      pcw
        vq.push_back(mk(0, 0, 0, 16'h0000, 0, 0, 1, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0)); // 0
        vq.push_back(mk(1, 1, 0, 16'h0000, 0, 0, 0, 16'h0000, 1, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0)); // 1 reset state
        vq.push_back(mk(1, 0, 1, 16'hA000, 1, 0, 0, 16'h0000, 1, 1, 16'h0000, 16'h0000, 0, 16'h0000, 0)); // 2 zero-wait ack
        vq.push_back(mk(1, 0, 0, 16'h0000, 1, 0, 0, 16'h0000, 1, 0, 16'h0000, 16'hA000, 1, 16'h0000, 1)); // 3 PCWrite
        vq.push_back(mk(1, 0, 1, 16'h1234, 0, 0, 0, 16'h0000, 1, 1, 16'h0002, 16'hA000, 0, 16'h0000, 0)); // 4 next at 2
        vq.push_back(mk(1, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 1, 0, 16'h0000, 16'h1234, 1, 16'h0002, 1)); // 5 FULL hold
        vq.push_back(mk(1, 0, 1, 16'hEEEE, 0, 0, 0, 16'h0000, 1, 0, 16'h0000, 16'h1234, 1, 16'h0002, 0)); // 6 ack ignored
        vq.push_back(mk(1, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 1, 0, 16'h0000, 16'h1234, 1, 16'h0002, 0)); // 7
        vq.push_back(mk(1, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 1, 0, 16'h0000, 16'h1234, 1, 16'h0002, 0)); // 8
        vq.push_back(mk(1, 0, 0, 16'h0000, 1, 0, 0, 16'h0000, 1, 0, 16'h0000, 16'h1234, 1, 16'h0002, 0)); // 9 take
        vq.push_back(mk(1, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 1, 1, 16'h0004, 16'h1234, 0, 16'h0002, 0)); // 10 delayed ack
        vq.push_back(mk(1, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 1, 1, 16'h0004, 16'h1234, 0, 16'h0002, 0)); // 11
        vq.push_back(mk(1, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 1, 1, 16'h0004, 16'h1234, 0, 16'h0002, 0)); // 12
        vq.push_back(mk(1, 0, 1, 16'h5678, 0, 0, 0, 16'h0000, 1, 1, 16'h0004, 16'h1234, 0, 16'h0002, 0)); // 13
        vq.push_back(mk(1, 0, 0, 16'h0000, 1, 0, 0, 16'h0000, 1, 0, 16'h0000, 16'h5678, 1, 16'h0004, 1)); // 14
        vq.push_back(mk(1, 0, 0, 16'h0000, 0, 1, 1, 16'h0040, 1, 1, 16'h0006, 16'h5678, 0, 16'h0004, 0)); // 15 flush in REQ
        vq.push_back(mk(1, 0, 1, 16'hDEAD, 0, 0, 0, 16'h0000, 1, 1, 16'h0040, 16'h5678, 0, 16'h0004, 0)); // 16 dropped ack
        vq.push_back(mk(1, 0, 1, 16'hBEEF, 0, 0, 0, 16'h0000, 1, 1, 16'h0040, 16'h5678, 0, 16'h0004, 0)); // 17 re-fetch
        vq.push_back(mk(1, 0, 0, 16'h0000, 0, 1, 1, 16'h0100, 1, 0, 16'h0000, 16'hBEEF, 1, 16'h0040, 1)); // 18 flush w/ PCWrite
        vq.push_back(mk(1, 0, 1, 16'h1111, 0, 1, 0, 16'h0000, 1, 1, 16'h0100, 16'hBEEF, 0, 16'h0040, 0)); // 19 flush+ack
        vq.push_back(mk(1, 0, 1, 16'h2222, 0, 0, 0, 16'h0000, 1, 1, 16'h0100, 16'hBEEF, 0, 16'h0040, 0)); // 20
        vq.push_back(mk(1, 0, 0, 16'h0000, 1, 1, 0, 16'h0000, 1, 0, 16'h0000, 16'h2222, 1, 16'h0100, 1)); // 21 flush+take
        vq.push_back(mk(1, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 1, 1, 16'h0102, 16'h2222, 0, 16'h0100, 0)); // 22
        vq.push_back(mk(0, 0, 1, 16'h3333, 0, 0, 1, 16'hFFFE, 1, 1, 16'h0102, 16'h2222, 0, 16'h0100, 0)); // 23 reset mid-REQ
        vq.push_back(mk(1, 0, 1, 16'h4444, 0, 0, 0, 16'h0000, 1, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0)); // 24 all zero
        vq.push_back(mk(1, 0, 1, 16'h4444, 0, 0, 0, 16'h0000, 1, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0)); // 25
        vq.push_back(mk(1, 1, 0, 16'h0000, 0, 0, 0, 16'h0000, 1, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0)); // 26
        vq.push_back(mk(1, 0, 1, 16'h7777, 0, 0, 0, 16'h0000, 1, 1, 16'hFFFE, 16'h0000, 0, 16'h0000, 0)); // 27 top PC
        vq.push_back(mk(1, 0, 0, 16'h0000, 1, 0, 0, 16'h0000, 1, 0, 16'h0000, 16'h7777, 1, 16'hFFFE, 1)); // 28
        vq.push_back(mk(1, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 1, 1, 16'h0000, 16'h7777, 0, 16'hFFFE, 0)); // 29 wrapped
        vq.push_back(mk(0, 0, 0, 16'h0000, 0, 0, 1, 16'h0020, 1, 1, 16'h0000, 16'h7777, 0, 16'hFFFE, 0)); // 30 reset
        vq.push_back(mk(1, 0, 0, 16'h0000, 0, 1, 0, 16'h0000, 1, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0)); // 31 flush in IDLE
        vq.push_back(mk(1, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 1, 1, 16'h0020, 16'h0000, 0, 16'h0000, 0)); // 32 REQ cycle 1

        foreach (vq[i]) begin
            Reset = vq[i].rst_n; Enable = vq[i].en; Mem_Ack = vq[i].ack;
            Mem_Data = vq[i].data; IR_Take = vq[i].take; Flush = vq[i].flush;
            pc_ld = vq[i].ld; pc_ldv = vq[i].ldv;
            #1;
            if (vq[i].chk) begin
                check($sformatf("v%0d Mem_Req", i),     16'(Mem_Req),     16'(vq[i].req));
                check($sformatf("v%0d Mem_Addr", i),    Mem_Addr,         vq[i].addr);
                check($sformatf("v%0d IR", i),          IR,               vq[i].ir);
                check($sformatf("v%0d IR_Valid", i),    16'(IR_Valid),    16'(vq[i].val));
                check($sformatf("v%0d Fetch_PC", i),    Fetch_PC,         vq[i].fpc);
                check($sformatf("v%0d PCWrite", i),     16'(PCWrite),     16'(vq[i].pcw));
                check($sformatf("v%0d Fetch_Error", i), 16'(Fetch_Error), 16'd0);
            end
            @(posedge CLK);
            #1;
        end

        // One REQ cycle without ack has elapsed; keep memory silent.
        drive_idle();
        #1;
`ifdef FETCH_TIMEOUT_EN
        for (int k = 2; k <= 15; k++) begin
            check($sformatf("timeout REQ cycle %0d Mem_Req", k), 16'(Mem_Req), 16'd1);
            check($sformatf("timeout REQ cycle %0d Fetch_Error", k), 16'(Fetch_Error), 16'd0);
            @(posedge CLK);
            #1;
        end
        for (int k = 0; k < 5; k++) begin
            Mem_Ack = 1'b1; Enable = 1'b1;
            #1;
            check($sformatf("halt %0d Mem_Req", k), 16'(Mem_Req), 16'd0);
            check($sformatf("halt %0d Fetch_Error", k), 16'(Fetch_Error), 16'd1);
            check($sformatf("halt %0d PCWrite", k), 16'(PCWrite), 16'd0);
            @(posedge CLK);
            #1;
        end
`else
        begin
            int pcw_seen;
            pcw_seen = 0;
            for (int k = 0; k < 100; k++) begin
                if (PCWrite) pcw_seen++;
                @(posedge CLK);
                #1;
            end
            check("no-ack wait Mem_Req", 16'(Mem_Req), 16'd1);
            check("no-ack wait Mem_Addr", Mem_Addr, 16'h0020);
            check("no-ack wait Fetch_Error", 16'(Fetch_Error), 16'd0);
            check("no-ack wait PCWrite count", 16'(pcw_seen), 16'd0);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
